// File: rtl/spu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spu_pkg: opcodes, ALU op classes and the RR-form opcode decoder.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package spu_pkg;

    localparam logic [10:0] OP_AH   = 11'b00011001000;
    localparam logic [10:0] OP_A    = 11'b00011000000;
    localparam logic [10:0] OP_SFH  = 11'b00001001000;
    localparam logic [10:0] OP_SF   = 11'b00001000000;
    localparam logic [10:0] OP_AND  = 11'b00011000001;
    localparam logic [10:0] OP_OR   = 11'b00001000001;
    localparam logic [10:0] OP_XOR  = 11'b01001000001;
    localparam logic [10:0] OP_CEQH = 11'b01111001000;
    localparam logic [10:0] OP_CEQ  = 11'b01111000000;

    typedef enum logic {
        ELEM_HALF = 1'b0,
        ELEM_WORD = 1'b1
    } elem_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SFX = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_CEQ = 3'd5
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        elem_e   elem;
        logic    illegal;
    } dec_t;

    function automatic dec_t decode(input logic [10:0] opc);
        dec_t d;
        d.op      = ALU_ADD;
        d.elem    = ELEM_WORD;
        d.illegal = 1'b0;
        case (opc)
            OP_AH:   begin d.op = ALU_ADD; d.elem = ELEM_HALF; end
            OP_A:    begin d.op = ALU_ADD; d.elem = ELEM_WORD; end
            OP_SFH:  begin d.op = ALU_SFX; d.elem = ELEM_HALF; end
            OP_SF:   begin d.op = ALU_SFX; d.elem = ELEM_WORD; end
            OP_AND:  d.op = ALU_AND;
            OP_OR:   d.op = ALU_OR;
            OP_XOR:  d.op = ALU_XOR;
            OP_CEQH: begin d.op = ALU_CEQ; d.elem = ELEM_HALF; end
            OP_CEQ:  begin d.op = ALU_CEQ; d.elem = ELEM_WORD; end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spu_fx_simd_pipe_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spu_simd_alu: combinational SIMD lane ALU, halfword or word elements.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spu_simd_alu
    import spu_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  alu_op_e            op,
    input  elem_e              elem,
    input  logic [DATA_W-1:0]  ra,
    input  logic [DATA_W-1:0]  rb,
    output logic [DATA_W-1:0]  rt
);

    genvar w;
    generate
        for (w = 0; w < DATA_W / 32; w++) begin : g_word
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] r;
            logic        half;

            assign a    = ra[32*w +: 32];
            assign b    = rb[32*w +: 32];
            assign half = (elem == ELEM_HALF);

            // Halfword results are built per half so no carry/borrow crosses bit 16.
            always_comb begin
                r = '0;
                case (op)
                    ALU_ADD: r = half ? {a[31:16] + b[31:16], a[15:0] + b[15:0]} : a + b;
                    ALU_SFX: r = half ? {b[31:16] - a[31:16], b[15:0] - a[15:0]} : b - a;
                    ALU_AND: r = a & b;
                    ALU_OR:  r = a | b;
                    ALU_XOR: r = a ^ b;
                    ALU_CEQ: r = half ? {{16{a[31:16] == b[31:16]}}, {16{a[15:0] == b[15:0]}}}
                                      : {32{a == b}};
                    default: r = '0;
                endcase
            end

            assign rt[32*w +: 32] = r;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spu_fx_simd_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spu_fx_simd_pipe: pipelined SIMD fixed-point execute unit, even pipe.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spu_fx_simd_pipe
    import spu_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_opcode,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rt,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              busy
);

    dec_t                                dec;
    logic [DATA_W-1:0]                   alu_rt;
    logic [DATA_W-1:0]                   res;
    logic [LATENCY-1:0]                  can_load;
    logic                                accept;

    logic [LATENCY-1:0]                  vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0]      rt_q,  rt_d;
    logic [LATENCY-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [LATENCY-1:0]                  ill_q, ill_d;

    assign dec = decode(in_opcode);

    spu_simd_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op   (dec.op),
        .elem (dec.elem),
        .ra   (in_ra),
        .rb   (in_rb),
        .rt   (alu_rt)
    );

    assign res = dec.illegal ? '0 : alu_rt;

    // A stage can load when out_ready is high or some stage at or after it is empty.
    always_comb begin
        logic full_run;
        full_run = 1'b1;
        can_load = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            full_run    = full_run & vld_q[k];
            can_load[k] = out_ready | ~full_run;
        end
    end

    assign in_ready = can_load[0] & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        vld_d = vld_q;
        rt_d  = rt_q;
        tag_d = tag_q;
        ill_d = ill_q;
        if (can_load[0]) begin
            vld_d[0] = accept;
            if (accept) begin
                rt_d[0]  = res;
                tag_d[0] = in_tag;
                ill_d[0] = dec.illegal;
            end
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (can_load[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    rt_d[k]  = rt_q[k-1];
                    tag_d[k] = tag_q[k-1];
                    ill_d[k] = ill_q[k-1];
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            rt_q  <= '0;
            tag_q <= '0;
            ill_q <= '0;
        end else begin
            vld_q <= vld_d;
            rt_q  <= rt_d;
            tag_q <= tag_d;
            ill_q <= ill_d;
        end
    end

    assign out_valid   = vld_q[LATENCY-1];
    assign out_rt      = rt_q[LATENCY-1];
    assign out_tag     = tag_q[LATENCY-1];
    assign out_illegal = ill_q[LATENCY-1];
    assign busy        = |vld_q;

endmodule
`default_nettype wire
